// File: rtl/axi_write_slave.sv
// AXI write-channel responder: accepts one AW/W burst at a time, writes beats into a
// byte-strobed SRAM port, and answers on B with OKAY or SLVERR.
module axi_write_slave #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   AWID,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic [7:0]            AWLEN,
    input  logic [2:0]            AWSIZE,
    input  logic [1:0]            AWBURST,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic [STRB_WIDTH-1:0] WSTRB,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [ID_WIDTH-1:0]   BID,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [STRB_WIDTH-1:0] mem_wstrb
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t                state_r;
    state_t                state_next_s;
    logic [ID_WIDTH-1:0]   bid_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [7:0]            len_r;
    logic [7:0]            cnt_r;
    logic [2:0]            size_r;
    logic [1:0]            burst_r;
    logic                  err_r;

    logic                  aw_hs_s;
    logic                  w_hs_s;
    logic                  last_beat_s;
    logic                  wlast_bad_s;
    logic [ADDR_WIDTH-1:0] addr_step_s;

    // WRAP and the reserved encoding are refused, as is any beat wider than the data bus.
    function automatic logic aw_illegal(input logic [1:0] burst, input logic [2:0] size);
        logic bad_size;
        bad_size = (32'd1 << size) > 32'(STRB_WIDTH);
        return burst[1] | bad_size;
    endfunction

    assign aw_hs_s     = AWVALID & (state_r == ST_IDLE);
    assign w_hs_s      = WVALID & (state_r == ST_DATA);
    assign last_beat_s = (cnt_r == len_r);
    assign wlast_bad_s = (WLAST != last_beat_s);
    assign addr_step_s = ADDR_WIDTH'(32'd1 << size_r);
    assign BID         = bid_r;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; the burst ends on beat count alone, never on WLAST.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (aw_hs_s) begin
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (w_hs_s && last_beat_s) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_RESP: begin
                if (BREADY) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Handshake and SRAM outputs decoded from the state register.
    always_comb begin
        AWREADY   = 1'b0;
        WREADY    = 1'b0;
        BVALID    = 1'b0;
        BRESP     = RESP_OKAY;
        mem_wen   = 1'b0;
        mem_addr  = addr_r;
        mem_wdata = WDATA;
        mem_wstrb = WSTRB;
        case (state_r)
            ST_IDLE: begin
                AWREADY = 1'b1;
            end
            ST_DATA: begin
                WREADY  = 1'b1;
                mem_wen = WVALID & ~err_r;
            end
            ST_RESP: begin
                BVALID = 1'b1;
                if (err_r) begin
                    BRESP = RESP_SLVERR;
                end else begin
                    BRESP = RESP_OKAY;
                end
            end
            default: begin
                AWREADY = 1'b0;
            end
        endcase
    end

    // Transaction context: captured on AW, advanced on every accepted W beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bid_r   <= '0;
            addr_r  <= '0;
            len_r   <= 8'd0;
            cnt_r   <= 8'd0;
            size_r  <= 3'd0;
            burst_r <= 2'b00;
            err_r   <= 1'b0;
        end else if (aw_hs_s) begin
            bid_r   <= AWID;
            addr_r  <= AWADDR;
            len_r   <= AWLEN;
            cnt_r   <= 8'd0;
            size_r  <= AWSIZE;
            burst_r <= AWBURST;
            err_r   <= aw_illegal(AWBURST, AWSIZE);
        end else if (w_hs_s) begin
            cnt_r <= cnt_r + 8'd1;
            if (burst_r == BURST_INCR) begin
                addr_r <= addr_r + addr_step_s;
            end else begin
                addr_r <= addr_r;
            end
            if (wlast_bad_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: tb/tb_axi_write_slave.sv
// Bench for axi_write_slave: directed table of bursts, reset-in-burst sequence, and
// randomized bursts checked against a burst-level reference model.
module tb_axi_write_slave;

    localparam int IDW = 4;
    localparam int AW  = 10;
    localparam int DW  = 64;
    localparam int SW  = DW / 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [IDW-1:0] AWID;
    logic [AW-1:0]  AWADDR;
    logic [7:0]     AWLEN;
    logic [2:0]     AWSIZE;
    logic [1:0]     AWBURST;
    logic           AWVALID;
    logic           AWREADY;
    logic [DW-1:0]  WDATA;
    logic [SW-1:0]  WSTRB;
    logic           WLAST;
    logic           WVALID;
    logic           WREADY;
    logic [IDW-1:0] BID;
    logic [1:0]     BRESP;
    logic           BVALID;
    logic           BREADY;
    logic           mem_wen;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic [SW-1:0]  mem_wstrb;

    axi_write_slave #(
        .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)
    ) dut (
        .clk(clk), .rst(rst),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  id;
        logic [9:0]  addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          bad_beat;
        int          hold;
        logic [23:0] strb3;
        logic [1:0]  exp_bresp;
        int          exp_nwr;
        logic [9:0]  exp_last_addr;
    } vec_t;

    vec_t        tbl [10];
    int          n_vec = 0;
    int          n_miss = 0;
    logic [63:0] wd [256];
    logic [7:0]  ws [256];
    logic [9:0]  exp_addr [$];
    logic [63:0] exp_data [$];
    logic [7:0]  exp_strb [$];
    logic [9:0]  obs_addr [$];
    logic [63:0] obs_data [$];
    logic [7:0]  obs_strb [$];
    logic [7:0]  r_len;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    int          r_bad;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Burst-level reference: which beats land in memory, where, and the final response.
    task automatic model(input logic [9:0] addr, input int nb, input logic [2:0] size,
                         input logic [1:0] burst, input int bad_beat, output logic [1:0] bresp);
        bit err;
        int step;
        step = 1 << size;
        err  = (burst == 2'b10) || (burst == 2'b11) || (step > SW);
        exp_addr.delete();
        exp_data.delete();
        exp_strb.delete();
        for (int i = 0; i < nb; i++) begin
            if (!err) begin
                exp_addr.push_back((burst == 2'b00) ? addr : 10'((int'(addr) + i * step) % 1024));
                exp_data.push_back(wd[i]);
                exp_strb.push_back(ws[i]);
            end
            if (i == bad_beat) err = 1'b1;
        end
        bresp = err ? 2'b10 : 2'b00;
    endtask

    task automatic do_txn(input logic [3:0] id, input logic [9:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int bad_beat,
                          input int hold, input logic [23:0] strb3, input bit rnd_strb,
                          input bit gaps, input int exp_bresp_in);
        int nb;
        logic [1:0] mdl_bresp;
        logic [1:0] exp_bresp;
        nb = int'(len) + 1;
        for (int i = 0; i < nb; i++) begin
            wd[i] = {$urandom(), $urandom()};
            if (rnd_strb) ws[i] = 8'($urandom());
            else if (i < 3) ws[i] = strb3[8*i +: 8];
            else ws[i] = strb3[23:16];
        end
        model(addr, nb, size, burst, bad_beat, mdl_bresp);
        exp_bresp = (exp_bresp_in < 0) ? mdl_bresp : 2'(exp_bresp_in);
        obs_addr.delete();
        obs_data.delete();
        obs_strb.delete();

        @(negedge clk);
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        #1;
        chk("aw_ready", AWREADY, 1'b1);
        chk("aw_bvalid_low", BVALID, 1'b0);
        for (int i = 0; i < nb; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                @(negedge clk);
                AWVALID = 1'b0; WVALID = 1'b0; WLAST = 1'b0;
                #1;
                chk("gap_no_write", mem_wen, 1'b0);
            end
            @(negedge clk);
            AWVALID = 1'b0; WVALID = 1'b1; WDATA = wd[i]; WSTRB = ws[i];
            WLAST = ((i == int'(len)) != (i == bad_beat));
            #1;
            chk("w_ready", WREADY, 1'b1);
            chk("aw_busy", AWREADY, 1'b0);
            if (mem_wen === 1'b1) begin
                obs_addr.push_back(mem_addr);
                obs_data.push_back(mem_wdata);
                obs_strb.push_back(mem_wstrb);
            end
        end

        @(negedge clk);
        WVALID = 1'b0; WLAST = 1'b0; BREADY = (hold == 0);
        #1;
        chk("b_valid", BVALID, 1'b1);
        chk("b_id", BID, id);
        chk("b_resp", BRESP, exp_bresp);
        chk("b_no_write", mem_wen, 1'b0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            BREADY = (h == hold - 1);
            #1;
            chk("b_hold_valid", BVALID, 1'b1);
            chk("b_hold_id", BID, id);
            chk("b_hold_resp", BRESP, exp_bresp);
            chk("b_hold_awready", AWREADY, 1'b0);
            chk("b_hold_wready", WREADY, 1'b0);
        end
        @(negedge clk);
        BREADY = 1'b0;
        #1;
        chk("aw_ready_after_b", AWREADY, 1'b1);
        chk("b_valid_drop", BVALID, 1'b0);

        chk("n_writes", obs_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            chk("wr_addr", obs_addr[i], exp_addr[i]);
            chk("wr_data", obs_data[i], exp_data[i]);
            chk("wr_strb", obs_strb[i], exp_strb[i]);
        end
    endtask

    initial begin
        rst = 1'b1;
        AWID = '0; AWADDR = '0; AWLEN = 8'd0; AWSIZE = 3'd0; AWBURST = 2'b00; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;

        tbl[0] = '{4'd3,  10'h040, 8'd3,   3'd3, 2'b01, -1, 0, 24'hFFFFFF, 2'b00, 4,   10'h058};
        tbl[1] = '{4'd1,  10'h3F8, 8'd1,   3'd3, 2'b01, -1, 0, 24'hFFFFFF, 2'b00, 2,   10'h000};
        tbl[2] = '{4'd2,  10'h100, 8'd2,   3'd3, 2'b00, -1, 0, 24'h81F00F, 2'b00, 3,   10'h100};
        tbl[3] = '{4'd4,  10'h080, 8'd1,   3'd3, 2'b10, -1, 0, 24'hFFFFFF, 2'b10, 0,   10'h000};
        tbl[4] = '{4'd6,  10'h000, 8'd1,   3'd4, 2'b01, -1, 0, 24'hFFFFFF, 2'b10, 0,   10'h000};
        tbl[5] = '{4'd7,  10'h200, 8'd2,   3'd3, 2'b01,  1, 5, 24'h3C5AA5, 2'b10, 2,   10'h208};
        tbl[6] = '{4'd9,  10'h010, 8'd0,   3'd0, 2'b01, -1, 1, 24'h000001, 2'b00, 1,   10'h010};
        tbl[7] = '{4'd15, 10'h300, 8'd255, 3'd0, 2'b01, -1, 2, 24'hFF5501, 2'b00, 256, 10'h3FF};
        tbl[8] = '{4'd8,  10'h020, 8'd0,   3'd3, 2'b11, -1, 0, 24'hFFFFFF, 2'b10, 0,   10'h000};
        tbl[9] = '{4'd10, 10'h3FC, 8'd1,   3'd2, 2'b01, -1, 3, 24'h0000F3, 2'b00, 2,   10'h000};

        @(negedge clk);
        #1;
        chk("rst_awready", AWREADY, 1'b1);
        chk("rst_wready", WREADY, 1'b0);
        chk("rst_bvalid", BVALID, 1'b0);
        chk("rst_bresp", BRESP, 2'b00);
        chk("rst_bid", BID, 4'd0);
        chk("rst_mem_wen", mem_wen, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int t = 0; t < 10; t++) begin
            do_txn(tbl[t].id, tbl[t].addr, tbl[t].len, tbl[t].size, tbl[t].burst, tbl[t].bad_beat,
                   tbl[t].hold, tbl[t].strb3, 1'b0, (t % 2) == 1, int'(tbl[t].exp_bresp));
            chk("tbl_nwr", obs_addr.size(), tbl[t].exp_nwr);
            if (tbl[t].exp_nwr > 0 && obs_addr.size() > 0)
                chk("tbl_last_addr", obs_addr[obs_addr.size() - 1], tbl[t].exp_last_addr);
        end

        // Reset asserted while beat 2 of a 4-beat burst is being offered.
        @(negedge clk);
        AWID = 4'd1; AWADDR = 10'h040; AWLEN = 8'd3; AWSIZE = 3'd3; AWBURST = 2'b01; AWVALID = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            AWVALID = 1'b0; WVALID = 1'b1; WDATA = 64'h1111_0000 + 64'(i); WSTRB = 8'hFF; WLAST = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_awready", AWREADY, 1'b1);
        chk("mid_rst_bvalid", BVALID, 1'b0);
        chk("mid_rst_mem_wen", mem_wen, 1'b0);
        chk("mid_rst_wready", WREADY, 1'b0);
        chk("mid_rst_bid", BID, 4'd0);
        @(negedge clk);
        rst = 1'b0; WVALID = 1'b0;
        do_txn(4'd5, 10'h0A0, 8'd0, 3'd3, 2'b01, -1, 0, 24'hFFFFFF, 1'b0, 1'b0, 0);
        chk("post_rst_nwr", obs_addr.size(), 1);

        for (int t = 0; t < 40; t++) begin
            r_len   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(16, 63)) : 8'($urandom_range(0, 7));
            r_size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            r_burst = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            r_bad   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, int'(r_len))) : -1;
            do_txn(4'($urandom()), 10'($urandom()), r_len, r_size, r_burst, r_bad,
                   int'($urandom_range(0, 3)), 24'h0, 1'b1, 1'b1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/axi_write_slave.md
Name: axi_write_slave

Overview:
- AXI write-channel responder: terminates AW/W/B traffic from an AXI write initiator and writes the beats into a byte-strobed on-chip SRAM port.
- Sits at the memory end of the write bus, opposite the LSU-side write interface.
- Handles one outstanding transaction at a time and supports FIXED and INCR bursts.
- Returns OKAY or SLVERR on B.

Parameters:
- ID_WIDTH, 4, width of AWID/BID.
- ADDR_WIDTH, 10, byte address width of AWADDR and mem_addr.
- DATA_WIDTH, 64, W data width.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- AWID  in  ID_WIDTH  write transaction ID.
- AWADDR  in  ADDR_WIDTH  start byte address.
- AWLEN  in  8  beats minus one.
- AWSIZE  in  3  log2 bytes per beat.
- AWBURST  in  2  burst type; 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- AWVALID  in  1  address valid.
- AWREADY  out  1  address accepted.
- WDATA  in  DATA_WIDTH  write data.
- WSTRB  in  STRB_WIDTH  byte enables.
- WLAST  in  1  final beat flag.
- WVALID  in  1  data valid.
- WREADY  out  1  data accepted.
- BID  out  ID_WIDTH  response ID.
- BRESP  out  2  00 OKAY, 10 SLVERR.
- BVALID  out  1  response valid.
- BREADY  in  1  response accepted.
- mem_wen  out  1  SRAM write strobe, one cycle per written beat.
- mem_addr  out  ADDR_WIDTH  SRAM byte address.
- mem_wdata  out  DATA_WIDTH  SRAM data.
- mem_wstrb  out  STRB_WIDTH  SRAM byte enables.

Behaviour:
- Interface: one clock (clk); asynchronous active-high reset (rst). Reset acts immediately, independent of clk.
- FSM states: IDLE, DATA, RESP. Reset state is IDLE.
- Reset values:
  - AWREADY=1 (decoded from IDLE); WREADY=0; BVALID=0; BRESP=00; BID=0; mem_wen=0.
  - Internal beat counter, address register and error flag all cleared.
- AWREADY = (state==IDLE). WREADY = (state==DATA). BVALID = (state==RESP).
- IDLE -> DATA on AWVALID&AWREADY. On that edge latch:
  - AWID into BID;
  - AWADDR into the address register;
  - AWLEN, AWSIZE, AWBURST;
  - clear beat counter to 0;
  - set err if AWBURST is 10 or 11, or if 2^AWSIZE > STRB_WIDTH.
- DATA, each W handshake (WVALID&WREADY):
  - if err=0: mem_wen=1 in the same cycle, combinationally; mem_addr = address register, mem_wdata = WDATA, mem_wstrb = WSTRB.
  - if err=1: beat is consumed and mem_wen stays 0.
  - INCR: address register += (1<<AWSIZE), modulo 2^ADDR_WIDTH (silent wrap at top of address space).
  - FIXED: address register unchanged.
  - beat counter += 1.
- WLAST check: on the beat where counter==AWLEN, WLAST must be 1; on any other beat WLAST must be 0. A mismatch sets err (the beat is still written if err was previously 0).
- Burst termination is by count only: DATA -> RESP after the handshake with counter==AWLEN. WLAST never ends the burst early.
- RESP: BRESP = err ? 10 : 00. BVALID and BID/BRESP are held stable until BREADY. On BVALID&BREADY -> IDLE, and AWREADY=1 the following cycle.
- Latency:
  - AW accept to first possible W accept: 1 cycle.
  - Sustained 1 beat/cycle in DATA.
  - Last W beat to BVALID: 1 cycle.
  - B handshake to next AWREADY: 1 cycle.
- W beats arriving while in IDLE or RESP are not accepted (WREADY=0).
- AW arriving while not in IDLE is not accepted.
- AWLEN=0: single beat; RESP follows that beat.
- AWLEN=255: counter is 8 bits, compare without overflow; 256 beats.
- Reset mid-burst or mid-response: immediately back to IDLE with reset values. No memory write occurs once rst is high. A pending B is dropped.

Test Plan:
- AWID=3, AWADDR=0x040, AWLEN=3, AWSIZE=3, INCR, 4 beats with WSTRB=0xFF, BREADY=1 -> mem_wen at 0x040/0x048/0x050/0x058; BVALID one cycle after 4th beat with BID=3, BRESP=00; AWREADY=1 on the next cycle.
- AWADDR=0x3F8, AWLEN=1, AWSIZE=3, INCR -> writes at 0x3F8 then 0x000 (address wrap); BRESP=00.
- AWBURST=00 (FIXED), AWADDR=0x100, AWLEN=2, WSTRB=0x0F,0xF0,0x81 -> three writes all at 0x100 with those strobes; BRESP=00.
- AWBURST=10 (WRAP), AWLEN=1 -> both beats accepted, mem_wen never asserted, BRESP=10. Separately AWSIZE=4 -> BRESP=10, no writes.
- AWLEN=2 with WLAST=1 on beat 1 -> 3 beats accepted, beats 0-1 written, beat 2 not written, BRESP=10. BREADY held 0 for 5 cycles -> BVALID/BID/BRESP stable, AWREADY=0, WREADY=0 throughout.
- rst pulsed high in DATA after beat 1 of a 4-beat burst -> AWREADY=1, BVALID=0, mem_wen=0 immediately. A new AWID=5, AWLEN=0 transaction afterwards completes with BID=5, BRESP=00.
